vga_mode_ctrl: RTL and testbench

Sequences glitch-free resolution switching of the VGA output between 640x480 and 800x600, driven by the user switch `sw`.
- Debounces `sw`, then waits for the timing generator's end-of-frame.
- Blanks RGB, holds the timing generator in reset, flips `mode_sel`, and keeps the output blanked for a few settle frames.
- Sits between board I/O and the VGA timing/pixel datapath.

---
 rtl/vga_ctrl_pkg.sv | 19 +
 rtl/vga_mode_ctrl_if.sv | 30 +++
 rtl/vga_mode_ctrl_sw_debounce.sv | 40 ++++
 rtl/vga_mode_ctrl.sv | 139 +++++++++++++
 tb/tb_vga_mode_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_ctrl_pkg.sv
// Shared types and widths for the VGA resolution-switch controller.
package vga_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        RESET_TG   = 2'd2,
        SETTLE     = 2'd3
    } state_e;

    localparam logic MODE_640_480 = 1'b0;
    localparam logic MODE_800_600 = 1'b1;

    localparam int unsigned DB_CNT_W  = 16;
    localparam int unsigned RST_CNT_W = 4;
    localparam int unsigned FRM_CNT_W = 4;
    localparam int unsigned TMO_CNT_W = 20;

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Board-side / timing-generator-side signals of the mode controller.
interface vga_mode_ctrl_if;
    logic sw;
    logic frame_end;
    logic mode_sel;
    logic tg_rst_n;
    logic blank;
    logic busy;
    logic timeout_err;

    modport master (
        output sw,
        output frame_end,
        input  mode_sel,
        input  tg_rst_n,
        input  blank,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  sw,
        input  frame_end,
        output mode_sel,
        output tg_rst_n,
        output blank,
        output busy,
        output timeout_err
    );
endinterface

// File: rtl/vga_mode_ctrl_sw_debounce.sv
// Two-flop synchronizer and stable-count debouncer for the mode switch.
module sw_debounce
    import vga_ctrl_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic sw_db
);

    localparam logic [DB_CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - DB_CNT_W'(1);

    logic                sw_meta;
    logic                sw_s;
    logic [DB_CNT_W-1:0] db_cnt;

    // Counter only runs while the synchronized input disagrees with sw_db.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
            sw_db   <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
            if (sw_s == sw_db) begin
                db_cnt <= '0;
            end else if (db_cnt >= DB_LAST) begin
                sw_db  <= sw_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Sequences blanked, reset-guarded switching of the VGA timing set on a
// frame boundary after the user switch has debounced.
module vga_mode_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter logic [DB_CNT_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [RST_CNT_W-1:0] RST_CYCLES      = 4'd4,
    parameter logic [FRM_CNT_W-1:0] SETTLE_FRAMES   = 4'd2,
    parameter logic [TMO_CNT_W-1:0] FRAME_TIMEOUT   = 20'd1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_mode_ctrl_if.slave   ctrl
);

    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CYCLES - RST_CNT_W'(1);
    localparam logic [FRM_CNT_W-1:0] FRM_LAST = SETTLE_FRAMES - FRM_CNT_W'(1);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = FRAME_TIMEOUT - TMO_CNT_W'(1);

    logic sw_db;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (ctrl.sw),
        .sw_db (sw_db)
    );

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic                   tg_rst_n_q, tg_rst_n_d;
    logic                   blank_q, blank_d;
    logic                   busy_q, busy_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [FRM_CNT_W-1:0]   frm_cnt_q, frm_cnt_d;

    // State and registered outputs; reset lands in SETTLE so power-up is blanked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SETTLE;
            mode_q     <= MODE_640_480;
            tg_rst_n_q <= 1'b1;
            blank_q    <= 1'b1;
            busy_q     <= 1'b1;
            tmo_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            frm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tg_rst_n_q <= tg_rst_n_d;
            blank_q    <= blank_d;
            busy_q     <= busy_d;
            tmo_err_q  <= tmo_err_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one edge ahead.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tg_rst_n_d = tg_rst_n_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        tmo_err_d  = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        frm_cnt_d  = frm_cnt_q;

        unique case (state_q)
            IDLE: begin
                tg_rst_n_d = 1'b1;
                blank_d    = 1'b0;
                busy_d     = 1'b0;
                if (sw_db != mode_q) begin
                    state_d   = WAIT_FRAME;
                    busy_d    = 1'b1;
                    tmo_cnt_d = '0;
                end
            end

            WAIT_FRAME: begin
                // A request withdrawn before the boundary wins over frame_end.
                if (sw_db == mode_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (ctrl.frame_end || (tmo_cnt_q >= TMO_LAST)) begin
                    state_d    = RESET_TG;
                    mode_d     = sw_db;
                    tg_rst_n_d = 1'b0;
                    blank_d    = 1'b1;
                    rst_cnt_d  = '0;
                    tmo_err_d  = !ctrl.frame_end;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
            end

            RESET_TG: begin
                if (rst_cnt_q >= RST_LAST) begin
                    state_d    = SETTLE;
                    tg_rst_n_d = 1'b1;
                    frm_cnt_d  = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end

            SETTLE: begin
                if (ctrl.frame_end) begin
                    if (frm_cnt_q >= FRM_LAST) begin
                        state_d = IDLE;
                        blank_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        frm_cnt_d = frm_cnt_q + FRM_CNT_W'(1);
                    end
                end
            end

            default: state_d = SETTLE;
        endcase
    end

    assign ctrl.mode_sel    = mode_q;
    assign ctrl.tg_rst_n    = tg_rst_n_q;
    assign ctrl.blank       = blank_q;
    assign ctrl.busy        = busy_q;
    assign ctrl.timeout_err = tmo_err_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl with a mode_sel scoreboard.
module tb_vga_mode_ctrl;

    localparam int SIG_BUSY  = 0;
    localparam int SIG_TGRST = 1;
    localparam int SIG_TMO   = 2;

    logic clk;
    logic rst_n;
    vga_mode_ctrl_if bus ();

    vga_mode_ctrl #(
        .DEBOUNCE_CYCLES (16'd8),
        .RST_CYCLES      (4'd4),
        .SETTLE_FRAMES   (4'd2),
        .FRAME_TIMEOUT   (20'd100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];

    // Frame generator and output monitors, all sampled/driven at negedge.
    logic fe_en = 1'b0;
    int   fcnt = 0;
    int   fe_cnt = 0;
    int   busy_hi = 0, tg_lo = 0, blank_hi = 0, tmo_pulses = 0;

    initial begin
        bus.frame_end = 1'b0;
        forever begin
            @(negedge clk);
            if (fe_en) begin
                fcnt++;
                bus.frame_end = (fcnt % 50 == 0);
                if (fcnt % 50 == 0) fe_cnt++;
            end else begin
                bus.frame_end = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1)        busy_hi++;
            if (bus.tg_rst_n === 1'b0)    tg_lo++;
            if (bus.blank === 1'b1)       blank_hi++;
            if (bus.timeout_err === 1'b1) tmo_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SIG_BUSY:  return bus.busy;
            SIG_TGRST: return bus.tg_rst_n;
            SIG_TMO:   return bus.timeout_err;
            default:   return bus.blank;
        endcase
    endfunction

    // Bounded wait for an output level; an expired bound is a failed check.
    task automatic wait_sig(input int sel, input logic val, input int max_cyc,
                            input string tag, output int cyc);
        cyc = 0;
        while (sig(sel) !== val && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(sig(sel)), 32'(val));
    endtask

    task automatic sb_pop(input string tag);
        logic e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus.mode_sel), 32'(e));
        end
    endtask

    task automatic count_tg_low(output int n);
        n = 0;
        while (bus.tg_rst_n === 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int cyc, n, snap_a, snap_b, snap_c, snap_t;

        rst_n  = 1'b0;
        bus.sw = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mode_sel", 32'(bus.mode_sel), 32'd0);
        chk("rst_tg_rst_n", 32'(bus.tg_rst_n), 32'd1);
        chk("rst_blank",    32'(bus.blank),    32'd1);
        chk("rst_busy",     32'(bus.busy),     32'd1);
        chk("rst_tmo_err",  32'(bus.timeout_err), 32'd0);

        // 1: power-up settle takes two frames
        rst_n = 1'b1;
        fe_en = 1'b1;
        wait_sig(SIG_BUSY, 1'b0, 200, "s1_idle", cyc);
        chk("s1_frames",   32'(fe_cnt),       32'd2);
        chk("s1_blank",    32'(bus.blank),    32'd0);
        chk("s1_mode_sel", 32'(bus.mode_sel), 32'd0);
        chk("s1_tg_rst_n", 32'(bus.tg_rst_n), 32'd1);

        // 2: clean 0->1 switch
        snap_t = tmo_pulses;
        bus.sw = 1'b1;
        exp_q.push_back(1'b1);
        wait_sig(SIG_BUSY, 1'b1, 40, "s2_busy", cyc);
        chk("s2_busy_latency", 32'(cyc), 32'd11);
        wait_sig(SIG_TGRST, 1'b0, 200, "s2_tg_low", cyc);
        sb_pop("s2_mode_sel");
        chk("s2_blank_on", 32'(bus.blank), 32'd1);
        snap_a = fe_cnt;
        count_tg_low(n);
        chk("s2_tg_low_cycles", 32'(n), 32'd4);
        chk("s2_blank_settle", 32'(bus.blank), 32'd1);
        wait_sig(SIG_BUSY, 1'b0, 300, "s2_idle", cyc);
        chk("s2_settle_frames", 32'(fe_cnt - snap_a), 32'd2);
        chk("s2_blank_off", 32'(bus.blank), 32'd0);
        chk("s2_mode_final", 32'(bus.mode_sel), 32'd1);
        chk("s2_no_timeout", 32'(tmo_pulses - snap_t), 32'd0);

        // return to 640x480 for the following scenarios
        bus.sw = 1'b0;
        exp_q.push_back(1'b0);
        wait_sig(SIG_TGRST, 1'b0, 300, "back_tg_low", cyc);
        sb_pop("back_mode_sel");
        wait_sig(SIG_BUSY, 1'b0, 300, "back_idle", cyc);

        // 3: short glitch is filtered
        snap_a = busy_hi;
        bus.sw = 1'b1;
        repeat (5) @(negedge clk);
        bus.sw = 1'b0;
        repeat (30) @(negedge clk);
        chk("s3_busy_never", 32'(busy_hi - snap_a), 32'd0);
        chk("s3_mode_sel",   32'(bus.mode_sel), 32'd0);

        // 4: request withdrawn before any frame boundary
        fe_en = 1'b0;
        snap_b = tg_lo;
        snap_c = blank_hi;
        snap_t = tmo_pulses;
        bus.sw = 1'b1;
        wait_sig(SIG_BUSY, 1'b1, 40, "s4_busy", cyc);
        bus.sw = 1'b0;
        wait_sig(SIG_BUSY, 1'b0, 60, "s4_abort", cyc);
        chk("s4_mode_sel",   32'(bus.mode_sel), 32'd0);
        chk("s4_tg_never",   32'(tg_lo - snap_b), 32'd0);
        chk("s4_blank_never", 32'(blank_hi - snap_c), 32'd0);
        chk("s4_no_timeout", 32'(tmo_pulses - snap_t), 32'd0);

        // 5: frame_end suppressed, timeout forces the switch
        repeat (15) @(negedge clk);
        snap_t = tmo_pulses;
        bus.sw = 1'b1;
        exp_q.push_back(1'b1);
        wait_sig(SIG_BUSY, 1'b1, 40, "s5_busy", cyc);
        wait_sig(SIG_TMO, 1'b1, 200, "s5_tmo", cyc);
        chk("s5_tmo_latency", 32'(cyc), 32'd100);
        chk("s5_tg_low", 32'(bus.tg_rst_n), 32'd0);
        sb_pop("s5_mode_sel");
        @(negedge clk);
        chk("s5_tmo_pulse_end", 32'(bus.timeout_err), 32'd0);
        chk("s5_tmo_once", 32'(tmo_pulses - snap_t), 32'd1);

        // 6: reset in the middle of RESET_TG
        fe_en  = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("s6_mode_sel", 32'(bus.mode_sel), 32'd0);
        chk("s6_tg_rst_n", 32'(bus.tg_rst_n), 32'd1);
        chk("s6_blank",    32'(bus.blank),    32'd1);
        chk("s6_busy",     32'(bus.busy),     32'd1);
        chk("s6_tmo_err",  32'(bus.timeout_err), 32'd0);
        rst_n = 1'b1;
        // switch still high: settle, then a fresh switch to 800x600
        exp_q.push_back(1'b1);
        wait_sig(SIG_TGRST, 1'b0, 400, "s6_tg_low", cyc);
        sb_pop("s6_mode_sel");
        wait_sig(SIG_BUSY, 1'b0, 300, "s6_idle", cyc);
        chk("s6_mode_final", 32'(bus.mode_sel), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
